btb_ctrl: RTL and testbench

- Sequences all writes into the branch target buffer.
- Buffers resolved-branch updates from the EXU in a small FIFO and drains them to the BTB write port at one per cycle.
- Runs an invalidate-all sweep on flush requests (fence.i, context switch) and masks predictions while the sweep is in progress.
- Sits between the EXU and the BTB update/invalidate ports; the IFU reads pred_block.

---
 rtl/btb_ctrl.sv | 167 ++++++++++++++++
 tb/tb_btb_ctrl.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/btb_ctrl.sv
// Branch target buffer write sequencer: an EXU update FIFO drained at one entry per cycle,
// plus an invalidate-all sweep on flush. Define BTB_CTRL_COALESCE_EN to merge same-PC updates.
module btb_ctrl #(
  parameter int BTB_ENTRIES = 1024,
  parameter int XLEN        = 32,
  parameter int QDEPTH      = 4
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           exu_upd_valid,
  output logic                           exu_upd_ready,
  input  logic [XLEN-1:0]                exu_upd_pc,
  input  logic [XLEN-1:0]                exu_upd_target,
  input  logic                           flush_req,
  output logic                           flush_busy,
  output logic                           flush_done,
  output logic                           btb_update_en,
  output logic [XLEN-1:0]                btb_update_pc,
  output logic [XLEN-1:0]                btb_update_target_pc,
  output logic                           btb_inv_en,
  output logic [$clog2(BTB_ENTRIES)-1:0] btb_inv_index,
  output logic                           pred_block,
  output logic [$clog2(QDEPTH):0]        q_count
);

  localparam int IW = $clog2(BTB_ENTRIES);
  localparam int AW = $clog2(QDEPTH);
  localparam logic [IW-1:0] LAST_IDX = IW'(BTB_ENTRIES - 1);

  typedef enum logic {
    RUN   = 1'b0,
    SWEEP = 1'b1
  } state_t;

  state_t          state;
  state_t          state_nxt;
  logic [IW-1:0]   sweep_cnt;
  logic            flush_done_q;

  logic [XLEN-1:0] mem_pc  [QDEPTH];
  logic [XLEN-1:0] mem_tgt [QDEPTH];
  logic [AW:0]     wr_ptr;
  logic [AW:0]     rd_ptr;
  logic [AW:0]     count;
  logic [AW-1:0]   wr_idx;
  logic [AW-1:0]   rd_idx;
  logic            empty;
  logic            full;
  logic            coal_hit;
  logic            start_sweep;
  logic            sweep_last;
  logic            push;
  logic            pop;

  assign count       = wr_ptr - rd_ptr;
  assign rd_idx      = rd_ptr[AW-1:0];
  assign empty       = (wr_ptr == rd_ptr);
  assign full        = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign start_sweep = (state == RUN) && flush_req;
  assign sweep_last  = (state == SWEEP) && (sweep_cnt == LAST_IDX);
  assign pop         = (state == RUN) && !flush_req && !empty;
  assign push        = exu_upd_valid && exu_upd_ready;

`ifdef BTB_CTRL_COALESCE_EN
  logic [AW-1:0] last_idx;

  // The newest entry is only mergeable if it is not also the head leaving this cycle.
  assign last_idx = wr_ptr[AW-1:0] - AW'(1);
  assign coal_hit = !empty && !(pop && (count == (AW+1)'(1))) &&
                    (mem_pc[last_idx] == exu_upd_pc);
  assign wr_idx   = coal_hit ? last_idx : wr_ptr[AW-1:0];
`else
  assign coal_hit = 1'b0;
  assign wr_idx   = wr_ptr[AW-1:0];
`endif

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= RUN;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    // NOTE: default first so no path through this block can infer a latch.
    state_nxt = state;
    unique case (state)
      RUN:     if (flush_req)  state_nxt = SWEEP;
      SWEEP:   if (sweep_last) state_nxt = RUN;
      default: state_nxt = RUN;
    endcase
  end

  // Output logic
  always_comb begin
    exu_upd_ready = 1'b0;
    btb_update_en = 1'b0;
    btb_inv_en    = 1'b0;
    btb_inv_index = '0;
    flush_busy    = 1'b0;
    pred_block    = 1'b0;
    unique case (state)
      RUN: begin
        exu_upd_ready = rst_n && !flush_req && (!full || coal_hit);
        btb_update_en = pop;
      end
      SWEEP: begin
        btb_inv_en    = 1'b1;
        btb_inv_index = sweep_cnt;
        flush_busy    = 1'b1;
        pred_block    = 1'b1;
      end
      default: ;
    endcase
  end

  assign btb_update_pc        = btb_update_en ? mem_pc[rd_idx]  : '0;
  assign btb_update_target_pc = btb_update_en ? mem_tgt[rd_idx] : '0;
  assign flush_done           = flush_done_q;
  assign q_count              = count;

  // Sweep counter; completion is detected by compare, the natural wrap is incidental.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sweep_cnt    <= '0;
      flush_done_q <= 1'b0;
    end else begin
      flush_done_q <= sweep_last;
      if (start_sweep) begin
        sweep_cnt <= '0;
      end else if (state == SWEEP) begin
        sweep_cnt <= sweep_cnt + IW'(1);
      end
    end
  end

  // FIFO pointers; a flush discards everything still queued as stale.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (start_sweep) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push && !coal_hit) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (pop)               rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  // NOTE: payload storage has no reset; only valid entries are ever read and outputs are gated.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_pc[wr_idx]  <= exu_upd_pc;
      mem_tgt[wr_idx] <= exu_upd_target;
    end
  end

  assert property (@(posedge clk) disable iff (!rst_n) count <= (AW+1)'(QDEPTH));
  assert property (@(posedge clk) disable iff (!rst_n) !(push && full && !coal_hit));
  assert property (@(posedge clk) disable iff (!rst_n) !(btb_update_en && btb_inv_en));

endmodule

// File: tb/tb_btb_ctrl.sv
// Self-checking bench for btb_ctrl: directed scenarios plus random traffic compared every
// cycle against a queue-based model of the update FIFO and the invalidate sweep.
module tb_btb_ctrl;

  localparam int BTB_ENTRIES = 1024;
  localparam int XLEN        = 32;
  localparam int QDEPTH      = 4;
`ifdef BTB_CTRL_COALESCE_EN
  localparam bit COAL = 1'b1;
`else
  localparam bit COAL = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            rst_n;
  logic            exu_upd_valid;
  logic            exu_upd_ready;
  logic [XLEN-1:0] exu_upd_pc;
  logic [XLEN-1:0] exu_upd_target;
  logic            flush_req;
  logic            flush_busy;
  logic            flush_done;
  logic            btb_update_en;
  logic [XLEN-1:0] btb_update_pc;
  logic [XLEN-1:0] btb_update_target_pc;
  logic            btb_inv_en;
  logic [9:0]      btb_inv_index;
  logic            pred_block;
  logic [2:0]      q_count;

  btb_ctrl #(.BTB_ENTRIES(BTB_ENTRIES), .XLEN(XLEN), .QDEPTH(QDEPTH)) dut (
    .clk                  (clk),
    .rst_n                (rst_n),
    .exu_upd_valid        (exu_upd_valid),
    .exu_upd_ready        (exu_upd_ready),
    .exu_upd_pc           (exu_upd_pc),
    .exu_upd_target       (exu_upd_target),
    .flush_req            (flush_req),
    .flush_busy           (flush_busy),
    .flush_done           (flush_done),
    .btb_update_en        (btb_update_en),
    .btb_update_pc        (btb_update_pc),
    .btb_update_target_pc (btb_update_target_pc),
    .btb_inv_en           (btb_inv_en),
    .btb_inv_index        (btb_inv_index),
    .pred_block           (pred_block),
    .q_count              (q_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] tgt;
  } ent_t;

  int   checks = 0;
  int   errors = 0;

  // Reference model: pending updates in arrival order, and sweep position.
  ent_t m_q[$];
  bit   m_sweep;
  int   m_idx;
  bit   m_done;

  // Observations of the DUT used by the directed literal checks.
  ent_t wr_log[$];
  int   inv_cnt;
  int   done_cnt;
  logic obs_en, obs_ready, obs_done;
  logic [31:0] obs_pc, obs_tgt;
  logic [2:0]  obs_qc;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    m_q.delete();
    m_sweep = 1'b0;
    m_idx   = 0;
    m_done  = 1'b0;
  endtask

  // One clock cycle: drive, compare against the model, then advance the model at the edge.
  task automatic step(input logic v, input logic [31:0] p, input logic [31:0] t, input logic f);
    logic e_run, e_coal, e_ready, e_en;
    @(negedge clk);
    exu_upd_valid  = v;
    exu_upd_pc     = p;
    exu_upd_target = t;
    flush_req      = f;
    #1;
    e_run   = !m_sweep;
    e_coal  = COAL && (m_q.size() >= 2) && (m_q[m_q.size()-1].pc == p);
    e_ready = e_run && !f && ((m_q.size() < QDEPTH) || e_coal);
    e_en    = e_run && !f && (m_q.size() > 0);
    check("ready", 32'(exu_upd_ready), 32'(e_ready));
    check("update_en", 32'(btb_update_en), 32'(e_en));
    if (e_en) begin
      check("update_pc", btb_update_pc, m_q[0].pc);
      check("update_target", btb_update_target_pc, m_q[0].tgt);
    end
    check("inv_en", 32'(btb_inv_en), 32'(m_sweep));
    if (m_sweep) check("inv_index", 32'(btb_inv_index), 32'(m_idx));
    check("flush_busy", 32'(flush_busy), 32'(m_sweep));
    check("pred_block", 32'(pred_block), 32'(m_sweep));
    check("flush_done", 32'(flush_done), 32'(m_done));
    check("q_count", 32'(q_count), 32'(m_q.size()));
    obs_en    = btb_update_en;
    obs_ready = exu_upd_ready;
    obs_done  = flush_done;
    obs_pc    = btb_update_pc;
    obs_tgt   = btb_update_target_pc;
    obs_qc    = q_count;
    if (btb_update_en) wr_log.push_back('{btb_update_pc, btb_update_target_pc});
    if (btb_inv_en)    inv_cnt++;
    if (flush_done)    done_cnt++;
    @(posedge clk);
    if (m_sweep) begin
      m_done = (m_idx == BTB_ENTRIES - 1);
      if (m_idx == BTB_ENTRIES - 1) m_sweep = 1'b0;
      else m_idx++;
    end else begin
      m_done = 1'b0;
      if (f) begin
        m_q.delete();
        m_sweep = 1'b1;
        m_idx   = 0;
      end else begin
        if (v && e_ready) begin
          if (e_coal) m_q[m_q.size()-1].tgt = t;
          else m_q.push_back('{p, t});
        end
        if (e_en) void'(m_q.pop_front());
      end
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ready"}, 32'(exu_upd_ready), 32'd0);
    check({tag, "_update_en"}, 32'(btb_update_en), 32'd0);
    check({tag, "_update_pc"}, btb_update_pc, 32'd0);
    check({tag, "_update_tgt"}, btb_update_target_pc, 32'd0);
    check({tag, "_inv_en"}, 32'(btb_inv_en), 32'd0);
    check({tag, "_inv_index"}, 32'(btb_inv_index), 32'd0);
    check({tag, "_busy"}, 32'(flush_busy), 32'd0);
    check({tag, "_done"}, 32'(flush_done), 32'd0);
    check({tag, "_pred_block"}, 32'(pred_block), 32'd0);
    check({tag, "_q_count"}, 32'(q_count), 32'd0);
  endtask

  // Assert reset part-way through the high phase, away from either clock edge.
  task automatic reset_mid(input string tag);
    #2;
    rst_n          = 1'b0;
    exu_upd_valid  = 1'b0;
    flush_req      = 1'b0;
    exu_upd_pc     = '0;
    exu_upd_target = '0;
    #1;
    check_reset_outputs(tag);
    model_clear();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    logic fr;
    rst_n          = 1'b0;
    exu_upd_valid  = 1'b0;
    exu_upd_pc     = '0;
    exu_upd_target = '0;
    flush_req      = 1'b0;
    model_clear();
    inv_cnt  = 0;
    done_cnt = 0;
    #3;
    check_reset_outputs("por");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Single update appears the cycle after acceptance, for exactly one cycle.
    step(1'b1, 32'h0000_1000, 32'h0000_2000, 1'b0);
    check("t1_accept_ready", 32'(obs_ready), 32'd1);
    step(1'b0, 32'h0, 32'h0, 1'b0);
    check("t1_en", 32'(obs_en), 32'd1);
    check("t1_pc", obs_pc, 32'h0000_1000);
    check("t1_tgt", obs_tgt, 32'h0000_2000);
    check("t1_qc_full", 32'(obs_qc), 32'd1);
    step(1'b0, 32'h0, 32'h0, 1'b0);
    check("t1_en_after", 32'(obs_en), 32'd0);
    check("t1_qc_empty", 32'(obs_qc), 32'd0);

    // Five back-to-back updates stream through without backpressure.
    wr_log.delete();
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 32'h100 + 32'(4 * i), 32'h900 + 32'(i), 1'b0);
      check("t2_ready", 32'(obs_ready), 32'd1);
    end
    step(1'b0, 32'h0, 32'h0, 1'b0);
    step(1'b0, 32'h0, 32'h0, 1'b0);
    check("t2_writes", 32'(wr_log.size()), 32'd5);
    for (int i = 0; i < 5 && i < wr_log.size(); i++) begin
      check("t2_order_pc", wr_log[i].pc, 32'h100 + 32'(4 * i));
      check("t2_order_tgt", wr_log[i].tgt, 32'h900 + 32'(i));
    end

    // Burst then flush: the still-queued update is dropped, full sweep, one done pulse.
    wr_log.delete();
    inv_cnt  = 0;
    done_cnt = 0;
    step(1'b1, 32'hA00, 32'hB00, 1'b0);
    step(1'b1, 32'hA04, 32'hB04, 1'b0);
    step(1'b1, 32'hA08, 32'hB08, 1'b0);
    step(1'b0, 32'h0, 32'h0, 1'b1);
    k = 0;
    do begin
      step(1'b0, 32'h0, 32'h0, 1'b0);
      k++;
    end while (!obs_done && k < 1100);
    check("t3_sweep_cycles", 32'(inv_cnt), 32'd1024);
    check("t3_done_count", 32'(done_cnt), 32'd1);
    check("t3_done_latency", 32'(k), 32'd1025);
    k = 0;
    foreach (wr_log[i]) if (wr_log[i].pc == 32'hA08) k++;
    check("t3_stale_written", 32'(k), 32'd0);
    step(1'b0, 32'h0, 32'h0, 1'b0);
    check("t3_ready_back", 32'(obs_ready), 32'd1);

    // Re-flush at index 500 is absorbed; completion timing unchanged.
    done_cnt = 0;
    step(1'b0, 32'h0, 32'h0, 1'b1);
    k = 0;
    do begin
      fr = m_sweep && (m_idx >= 500) && (m_idx < 504);
      step(1'b0, 32'h0, 32'h0, fr);
      k++;
    end while (!obs_done && k < 1200);
    check("t4_done_latency", 32'(k), 32'd1025);
    check("t4_done_count", 32'(done_cnt), 32'd1);

    // Reset at sweep index 10: immediate abort and no completion pulse.
    done_cnt = 0;
    step(1'b0, 32'h0, 32'h0, 1'b1);
    k = 0;
    while (!(m_sweep && m_idx == 10) && k < 50) begin
      step(1'b0, 32'h0, 32'h0, 1'b0);
      k++;
    end
    reset_mid("mid_sweep_rst");
    for (int i = 0; i < 1100; i++) step(1'b0, 32'h0, 32'h0, 1'b0);
    check("t5_no_done", 32'(done_cnt), 32'd0);
    step(1'b1, 32'h0000_3000, 32'h0000_3004, 1'b0);
    step(1'b0, 32'h0, 32'h0, 1'b0);
    check("t5_post_en", 32'(obs_en), 32'd1);
    check("t5_post_pc", obs_pc, 32'h0000_3000);

    // Same PC back-to-back: first entry is already draining, so two writes in order.
    wr_log.delete();
    step(1'b1, 32'h40, 32'h80, 1'b0);
    step(1'b1, 32'h40, 32'hC0, 1'b0);
    step(1'b0, 32'h0, 32'h0, 1'b0);
    step(1'b0, 32'h0, 32'h0, 1'b0);
    check("t6_writes", 32'(wr_log.size()), 32'd2);
    if (wr_log.size() == 2) begin
      check("t6_first_tgt", wr_log[0].tgt, 32'h80);
      check("t6_second_tgt", wr_log[1].tgt, 32'hC0);
    end

    // pc==0 is ordinary data.
    step(1'b1, 32'h0, 32'h1234, 1'b0);
    step(1'b0, 32'h0, 32'h0, 1'b0);
    check("t7_zero_pc_en", 32'(obs_en), 32'd1);
    check("t7_zero_pc_tgt", obs_tgt, 32'h1234);

    // Random traffic from a small PC pool so repeats and flush overlaps occur.
    for (int i = 0; i < 5000; i++) begin
      step(1'($urandom_range(0, 1)),
           32'h40 * $urandom_range(0, 3),
           $urandom,
           ($urandom_range(0, 299) == 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
